feature_frame_builder: RTL and testbench



---
 rtl/mlp_pkg.sv | 26 ++
 rtl/ffb_ch_accum.sv | 34 +++
 rtl/feature_frame_builder.sv | 142 ++++++++++++++
 tb/tb_feature_frame_builder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared MLP front-end types and the feature averaging helper.
// FFB_ROUND_EN selects round-half-up averaging; default is truncation.
package mlp_pkg;

  localparam int unsigned MLP_NUM_IN   = 6;
  localparam int unsigned MLP_DW       = 8;
  localparam int unsigned AVG_MAX_LOG2 = 4;
  localparam int unsigned SUM_W        = MLP_DW + AVG_MAX_LOG2;
  localparam int unsigned SUM_W1       = SUM_W + 1;

  typedef logic [MLP_DW-1:0] feat_t;
  typedef feat_t feat_vec_t [MLP_NUM_IN];

  // Divide an accumulated sum by 2^log2, saturating to the feature range.
  function automatic feat_t avg_div(input logic [SUM_W-1:0] sum, input int unsigned log2);
    logic [SUM_W1-1:0] tmp;
    tmp = {1'b0, sum};
`ifdef FFB_ROUND_EN
    if (log2 != 0) tmp = tmp + (SUM_W1'(1) << (log2 - 1));
`endif
    tmp = tmp >> log2;
    if (tmp > SUM_W1'(2**MLP_DW - 1)) avg_div = '1;
    else avg_div = feat_t'(tmp);
  endfunction

endpackage

// File: rtl/ffb_ch_accum.sv
// Per-channel sample accumulator: round 0 loads, later rounds add.
// sum_nxt_c exposes the post-update sum so a finishing frame sees its last sample.
module ffb_ch_accum
  import mlp_pkg::*;
#(
  parameter int unsigned DW       = MLP_DW,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   load_i,
  input  logic                   add_i,
  input  logic [DW-1:0]          data_i,
  output logic [DW+AVG_LOG2-1:0] sum_nxt_c
);

  localparam int unsigned AW = DW + AVG_LOG2;

  logic [AW-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (load_i)     sum_d = AW'(data_i);
    else if (add_i) sum_d = sum_q + AW'(data_i);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) sum_q <= '0;
    else         sum_q <= sum_d;
  end

  assign sum_nxt_c = sum_d;

endmodule

// File: rtl/feature_frame_builder.sv
// Builds averaged NUM_CH-wide feature frames from a channel-ordered sample stream.
// Build option FFB_ROUND_EN switches feature averaging to round-half-up.
module feature_frame_builder
  import mlp_pkg::*;
#(
  parameter int unsigned NUM_CH   = MLP_NUM_IN,
  parameter int unsigned DW       = MLP_DW,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic                                                clk_i,
  input  logic                                                rstn_i,
  input  logic                                                clear_i,
  input  logic                                                s_valid_i,
  output logic                                                s_ready_o,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]      s_ch_i,
  input  logic [DW-1:0]                                       s_data_i,
  output logic                                                f_valid_o,
  input  logic                                                f_ready_i,
  output logic [NUM_CH-1:0][DW-1:0]                           feat_o,
  output logic                                                seq_err_o,
  output logic [7:0]                                          err_cnt_o
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned RND_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned AW    = DW + AVG_LOG2;
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [RND_W-1:0] RND_LAST = RND_W'((1 << AVG_LOG2) - 1);

  logic [CH_W-1:0]           ch_cnt_q, ch_cnt_d;
  logic [RND_W-1:0]          rnd_cnt_q, rnd_cnt_d;
  logic                      f_valid_q, f_valid_d;
  logic [NUM_CH-1:0][DW-1:0] feat_q, feat_d, feat_c;
  logic                      seq_err_q, seq_err_d;
  logic [7:0]                err_cnt_q, err_cnt_d;

  logic [NUM_CH-1:0]         load_c, add_c;
  logic [NUM_CH-1:0][AW-1:0] sum_nxt;
  logic                      last_pos_c, accept_c, ch_ok_c;

  assign last_pos_c = (ch_cnt_q == CH_LAST) && (rnd_cnt_q == RND_LAST);
  // Stall only the sample that would overwrite a frame still waiting downstream.
  assign s_ready_o  = clear_i || !(last_pos_c && f_valid_q && !f_ready_i);
  assign accept_c   = s_valid_i && s_ready_o && !clear_i;
  assign ch_ok_c    = (s_ch_i == ch_cnt_q);

  // Accumulator strobes; a channel-0 resync sample restarts channel 0.
  always_comb begin
    load_c = '0;
    add_c  = '0;
    if (accept_c) begin
      if (ch_ok_c) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_cnt_q == CH_W'(c)) begin
            load_c[c] = (rnd_cnt_q == '0);
            add_c[c]  = (rnd_cnt_q != '0);
          end
        end
      end else if (s_ch_i == '0) begin
        load_c[0] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ffb_ch_accum #(.DW(DW), .AVG_LOG2(AVG_LOG2)) u_accum (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .load_i    (load_c[g]),
      .add_i     (add_c[g]),
      .data_i    (s_data_i),
      .sum_nxt_c (sum_nxt[g])
    );
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      feat_c[c] = DW'(avg_div(SUM_W'(sum_nxt[c]), AVG_LOG2));
    end
  end

  always_comb begin
    ch_cnt_d  = ch_cnt_q;
    rnd_cnt_d = rnd_cnt_q;
    f_valid_d = f_valid_q;
    feat_d    = feat_q;
    seq_err_d = 1'b0;
    err_cnt_d = err_cnt_q;
    if (clear_i) begin
      ch_cnt_d  = '0;
      rnd_cnt_d = '0;
      f_valid_d = 1'b0;
    end else begin
      if (f_valid_q && f_ready_i) f_valid_d = 1'b0;
      if (accept_c) begin
        if (ch_ok_c) begin
          if (ch_cnt_q == CH_LAST) begin
            ch_cnt_d = '0;
            if (rnd_cnt_q == RND_LAST) begin
              rnd_cnt_d = '0;
              f_valid_d = 1'b1;
              feat_d    = feat_c;
            end else begin
              rnd_cnt_d = rnd_cnt_q + RND_W'(1);
            end
          end else begin
            ch_cnt_d = ch_cnt_q + CH_W'(1);
          end
        end else begin
          seq_err_d = 1'b1;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          rnd_cnt_d = '0;
          ch_cnt_d  = (s_ch_i == '0) ? CH_W'(1) : '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ch_cnt_q  <= '0;
      rnd_cnt_q <= '0;
      f_valid_q <= 1'b0;
      feat_q    <= '0;
      seq_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      ch_cnt_q  <= ch_cnt_d;
      rnd_cnt_q <= rnd_cnt_d;
      f_valid_q <= f_valid_d;
      feat_q    <= feat_d;
      seq_err_q <= seq_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign f_valid_o = f_valid_q;
  assign feat_o    = feat_q;
  assign seq_err_o = seq_err_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_feature_frame_builder.sv
// Directed bench for feature_frame_builder: frame table plus handshake, error, clear and reset sequences.
module tb_feature_frame_builder;

  localparam int unsigned NUM_CH = 6;
  localparam int unsigned DW     = 8;
  localparam int unsigned CH_W   = 3;
  localparam int unsigned NRND   = 4;
  localparam int unsigned VW     = NUM_CH * DW;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic          clear_i = 1'b0;
  logic          s_valid_i = 1'b0;
  logic          s_ready_o;
  logic [CH_W-1:0] s_ch_i = '0;
  logic [DW-1:0] s_data_i = '0;
  logic          f_valid_o;
  logic          f_ready_i = 1'b0;
  logic [NUM_CH-1:0][DW-1:0] feat_o;
  logic          seq_err_o;
  logic [7:0]    err_cnt_o;

  feature_frame_builder #(.NUM_CH(NUM_CH), .DW(DW), .AVG_LOG2(2)) dut (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .clear_i   (clear_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .s_ch_i    (s_ch_i),
    .s_data_i  (s_data_i),
    .f_valid_o (f_valid_o),
    .f_ready_i (f_ready_i),
    .feat_o    (feat_o),
    .seq_err_o (seq_err_o),
    .err_cnt_o (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string                    name;
    logic [NRND-1:0][DW-1:0]  v;
    logic [DW-1:0]            choff;
    logic [DW-1:0]            exp_trunc;
    logic [DW-1:0]            exp_round;
  } frame_vec_t;

  frame_vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic frame_vec_t mk(input string name, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                    input logic [DW-1:0] c, input logic [DW-1:0] d, input logic [DW-1:0] off,
                                    input logic [DW-1:0] et, input logic [DW-1:0] er);
    frame_vec_t f;
    f.name = name;
    f.v[0] = a; f.v[1] = b; f.v[2] = c; f.v[3] = d;
    f.choff = off; f.exp_trunc = et; f.exp_round = er;
    return f;
  endfunction

  // Expected vector: channel c carries base + c*step.
  function automatic logic [VW-1:0] vec_of(input logic [DW-1:0] base, input logic [DW-1:0] step);
    logic [VW-1:0] v;
    for (int c = 0; c < NUM_CH; c++) v[c*DW +: DW] = base + DW'(c) * step;
    return v;
  endfunction

  function automatic logic [DW-1:0] pick(input frame_vec_t f);
`ifdef FFB_ROUND_EN
    return f.exp_round;
`else
    return f.exp_trunc;
`endif
  endfunction

  // Present one sample at a negedge and return on the negedge after it is accepted.
  task automatic drive(input logic [CH_W-1:0] ch, input logic [DW-1:0] d);
    int n;
    s_valid_i = 1'b1;
    s_ch_i    = ch;
    s_data_i  = d;
    #1;
    n = 0;
    while (!s_ready_o && n < 50) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    if (!s_ready_o) begin
      n_checks++;
      n_errors++;
      $display("FAIL drive_timeout: ch %0d s_ready_o=%0b, expected 1", ch, s_ready_o);
    end
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    s_valid_i = 1'b0;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic send_frame(input logic [NRND-1:0][DW-1:0] v, input logic [DW-1:0] off);
    for (int r = 0; r < NRND; r++)
      for (int c = 0; c < NUM_CH; c++)
        drive(CH_W'(c), v[r] + DW'(c) * off);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NRND-1:0][DW-1:0] v;
    logic [VW-1:0] expv, held;
    logic [DW-1:0] ea;

    vecs[0] = mk("ramp",       8'd10,  8'd11,  8'd12, 8'd13, 8'd1, 8'd11,  8'd12);
    vecs[1] = mk("full_scale", 8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd255, 8'd255);
    vecs[2] = mk("tiny",       8'd0,   8'd0,   8'd0,  8'd1,  8'd0, 8'd0,   8'd0);
    vecs[3] = mk("half",       8'd0,   8'd1,   8'd1,  8'd0,  8'd0, 8'd0,   8'd1);
    vecs[4] = mk("mixed",      8'd100, 8'd200, 8'd50, 8'd5,  8'd1, 8'd88,  8'd89);
    vecs[5] = mk("flat7_off",  8'd7,   8'd7,   8'd7,  8'd7,  8'd2, 8'd7,   8'd7);

    // Reset state
    repeat (2) @(negedge clk_i);
    check("rst_f_valid", 64'(f_valid_o), 64'd0);
    check("rst_feat",    64'(feat_o),    64'd0);
    check("rst_seq_err", 64'(seq_err_o), 64'd0);
    check("rst_err_cnt", 64'(err_cnt_o), 64'd0);
    check("rst_s_ready", 64'(s_ready_o), 64'd1);
    rstn_i = 1'b1;
    @(negedge clk_i);

    // Frame table, downstream always ready
    f_ready_i = 1'b1;
    foreach (vecs[k]) begin
      expv = vec_of(pick(vecs[k]), vecs[k].choff);
      for (int r = 0; r < NRND; r++)
        for (int c = 0; c < NUM_CH; c++) begin
          drive(CH_W'(c), vecs[k].v[r] + DW'(c) * vecs[k].choff);
          if (r == NRND-1 && c == NUM_CH-2)
            check({vecs[k].name, "_pre_valid"}, 64'(f_valid_o), 64'd0);
        end
      check({vecs[k].name, "_valid"},   64'(f_valid_o), 64'd1);
      check({vecs[k].name, "_feat"},    64'(feat_o),    64'(expv));
      check({vecs[k].name, "_seq_err"}, 64'(seq_err_o), 64'd0);
      idle(1);
      check({vecs[k].name, "_consumed"}, 64'(f_valid_o), 64'd0);
      check({vecs[k].name, "_hold"},     64'(feat_o),    64'(expv));
    end

    // Backpressure: pending frame A, second frame B stalls on its last sample
    f_ready_i = 1'b0;
    ea = pick(vecs[0]);
    send_frame(vecs[0].v, 8'd0);
    check("bp_a_valid", 64'(f_valid_o), 64'd1);
    check("bp_a_feat",  64'(feat_o),    64'(vec_of(ea, 8'd0)));
    for (int r = 0; r < NRND; r++)
      for (int c = 0; c < NUM_CH; c++)
        if (!(r == NRND-1 && c == NUM_CH-1)) drive(CH_W'(c), 8'd7);
    s_valid_i = 1'b1; s_ch_i = 3'd5; s_data_i = 8'd7;
    #1;
    check("bp_stall_ready", 64'(s_ready_o), 64'd0);
    @(negedge clk_i);
    #1;
    check("bp_stall_ready2", 64'(s_ready_o), 64'd0);
    check("bp_stall_valid",  64'(f_valid_o), 64'd1);
    check("bp_stall_feat",   64'(feat_o),    64'(vec_of(ea, 8'd0)));
    f_ready_i = 1'b1;
    #1;
    check("bp_release_ready", 64'(s_ready_o), 64'd1);
    @(negedge clk_i);
    s_valid_i = 1'b0;
    check("bp_b2b_valid", 64'(f_valid_o), 64'd1);
    check("bp_b2b_feat",  64'(feat_o),    64'(vec_of(8'd7, 8'd0)));
    @(negedge clk_i);
    check("bp_b_consumed", 64'(f_valid_o), 64'd0);

    // Sequence error: 0,1,3 drops sample 3
    drive(3'd0, 8'd1);
    drive(3'd1, 8'd2);
    drive(3'd3, 8'd9);
    s_valid_i = 1'b0;
    check("se_pulse",   64'(seq_err_o), 64'd1);
    check("se_cnt1",    64'(err_cnt_o), 64'd1);
    @(negedge clk_i);
    check("se_pulse_end", 64'(seq_err_o), 64'd0);
    check("se_no_frame",  64'(f_valid_o), 64'd0);
    v = {8'd7, 8'd7, 8'd7, 8'd7};
    send_frame(v, 8'd0);
    check("se_clean_valid", 64'(f_valid_o), 64'd1);
    check("se_clean_feat",  64'(feat_o),    64'(vec_of(8'd7, 8'd0)));
    check("se_clean_cnt",   64'(err_cnt_o), 64'd1);
    idle(1);

    // Resync on a ch0 mismatch keeps that sample as round 0 of channel 0
    drive(3'd0, 8'd8);
    drive(3'd1, 8'd8);
    drive(3'd2, 8'd8);
    drive(3'd0, 8'd20);
    check("rs_pulse", 64'(seq_err_o), 64'd1);
    check("rs_cnt2",  64'(err_cnt_o), 64'd2);
    for (int c = 1; c < NUM_CH; c++) drive(CH_W'(c), 8'd8);
    for (int r = 1; r < NRND; r++)
      for (int c = 0; c < NUM_CH; c++) drive(CH_W'(c), 8'd8);
    held = vec_of(8'd8, 8'd0);
    held[DW-1:0] = 8'd11;
    check("rs_valid",   64'(f_valid_o), 64'd1);
    check("rs_seq_err", 64'(seq_err_o), 64'd0);
    check("rs_feat",    64'(feat_o),    64'(held));
    idle(1);

    // Saturating error counter, out-of-range channels
    s_valid_i = 1'b1; s_ch_i = 3'd7; s_data_i = 8'd0;
    repeat (299) @(negedge clk_i);
    s_ch_i = 3'd6;
    @(negedge clk_i);
    check("sat_pulse", 64'(seq_err_o), 64'd1);
    check("sat_cnt",   64'(err_cnt_o), 64'd255);
    s_valid_i = 1'b0;
    @(negedge clk_i);
    check("sat_pulse_end", 64'(seq_err_o), 64'd0);
    check("sat_cnt_hold",  64'(err_cnt_o), 64'd255);
    check("sat_no_frame",  64'(f_valid_o), 64'd0);
    check("sat_feat_hold", 64'(feat_o),    64'(held));

    // Clear mid-frame
    for (int i = 0; i < 10; i++) drive(CH_W'(i % NUM_CH), 8'd5);
    clear_i = 1'b1; s_valid_i = 1'b1; s_ch_i = 3'd4; s_data_i = 8'd200;
    #1;
    check("clr_ready", 64'(s_ready_o), 64'd1);
    @(negedge clk_i);
    clear_i = 1'b0; s_valid_i = 1'b0;
    check("clr_valid",   64'(f_valid_o), 64'd0);
    check("clr_feat",    64'(feat_o),    64'(held));
    check("clr_err_cnt", 64'(err_cnt_o), 64'd255);
    v = {8'd9, 8'd9, 8'd9, 8'd9};
    send_frame(v, 8'd0);
    check("clr_next_valid",   64'(f_valid_o), 64'd1);
    check("clr_next_feat",    64'(feat_o),    64'(vec_of(8'd9, 8'd0)));
    check("clr_next_seq_err", 64'(seq_err_o), 64'd0);
    f_ready_i = 1'b0; s_valid_i = 1'b0;
    @(negedge clk_i);
    check("clr_pending", 64'(f_valid_o), 64'd1);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    check("clr_drop_pending", 64'(f_valid_o), 64'd0);
    check("clr_pending_feat", 64'(feat_o),    64'(vec_of(8'd9, 8'd0)));

    // Reset mid-frame
    f_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) drive(CH_W'(i % NUM_CH), 8'd3);
    s_valid_i = 1'b0;
    rstn_i = 1'b0;
    #1;
    check("mrst_valid",   64'(f_valid_o), 64'd0);
    check("mrst_feat",    64'(feat_o),    64'd0);
    check("mrst_err_cnt", 64'(err_cnt_o), 64'd0);
    check("mrst_seq_err", 64'(seq_err_o), 64'd0);
    check("mrst_ready",   64'(s_ready_o), 64'd1);
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    check("mrst_idle_valid", 64'(f_valid_o), 64'd0);
    send_frame(vecs[0].v, 8'd0);
    check("mrst_frame_valid", 64'(f_valid_o), 64'd1);
    check("mrst_frame_feat",  64'(feat_o),    64'(vec_of(ea, 8'd0)));
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
